// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and helpers used by the key schedule
package aes_pkg;
  typedef logic [7:0] ByteType;
  typedef enum logic [1:0] {IDLE, R0, EXPAND, PRESENT} ks_state_t;
  localparam ByteType RCON_INIT = 8'h01;
  localparam ByteType RCON_POLY = 8'h1B;
  localparam int AES128_NR = 10;
  function automatic ByteType xtime(input ByteType x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: round-constant register, reloaded to 0x01 or advanced by xtime
module aes_rcon_gen import aes_pkg::*; (
  input  logic       clk,
  input  logic       nrst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] rcon
);
  // load has priority so an abort or a fresh start always restarts the sequence
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) rcon <= RCON_INIT;
    else if (load) rcon <= RCON_INIT;
    else if (adv) rcon <= xtime(rcon);
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences AES-128 key expansion and hands round keys to the cipher
module aes_key_sched_ctrl import aes_pkg::*; #(
  parameter int PIPE_LAT   = 2,
  parameter int NUM_ROUNDS = AES128_NR
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [3:0] rk_round,
  output logic       rk_src,
  output logic       kg_en,
  output logic       kg_next_rnd,
  output logic       kg_gen_key,
  output logic [7:0] kg_rcon
);
  localparam int CW = $clog2(PIPE_LAT + 1);
  ks_state_t state;
  logic [3:0] round;
  logic [CW-1:0] cnt;
  logic hs, last;
  assign rk_valid    = (state == R0) || (state == PRESENT);
  assign hs          = rk_valid & rk_ready;
  assign last        = round == 4'(NUM_ROUNDS);
  assign busy        = state != IDLE;
  assign rk_round    = (state == PRESENT) ? round : 4'd0;
  assign rk_src      = state == PRESENT;
  assign kg_en       = state == EXPAND;
  assign kg_next_rnd = (state == EXPAND) && (round != 4'd1);
  assign kg_gen_key  = 1'b1;
  aes_rcon_gen u_rcon (
    .clk  (clk),
    .nrst (nrst),
    .load (abort || (state == IDLE) || ((state == PRESENT) && hs && last)),
    .adv  (!abort && (state == PRESENT) && hs && !last),
    .rcon (kg_rcon)
  );
  // round sequencing: present round 0, then expand/present each round until NUM_ROUNDS
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      round <= 4'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        round <= 4'd0;
        cnt   <= '0;
      end else
        case (state)
          IDLE: if (start) state <= R0;
          R0: if (hs) begin
            round <= 4'd1;
            cnt   <= CW'(PIPE_LAT - 1);
            state <= EXPAND;
          end
          EXPAND: if (cnt == '0) state <= PRESENT; else cnt <= cnt - 1'b1;
          PRESENT: if (hs) begin
            if (last) begin
              state <= IDLE;
              round <= 4'd0;
              done  <= 1'b1;
            end else begin
              round <= round + 4'd1;
              cnt   <= CW'(PIPE_LAT - 1);
              state <= EXPAND;
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: timeline model of the key schedule controller plus an AES key datapath model
module tb_aes_key_sched_ctrl;
  localparam int PL = 2;
  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, abort = 1'b0, rk_ready = 1'b0;
  logic busy, done, rk_valid, rk_src, kg_en, kg_next_rnd, kg_gen_key;
  logic [3:0] rk_round;
  logic [7:0] kg_rcon;
  logic [127:0] s1, key_o;
  logic [7:0] rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int errors = 0, checks = 0, done_at;
  always #5 clk = ~clk;
  aes_key_sched_ctrl #(.PIPE_LAT(PL), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round), .rk_src(rk_src),
    .kg_en(kg_en), .kg_next_rnd(kg_next_rnd), .kg_gen_key(kg_gen_key), .kg_rcon(kg_rcon)
  );
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) s = 8'(y);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 ^= t;
    w1 ^= w0;
    w2 ^= w1;
    w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction
  // two-stage key generator driven by the controller: input select, then one expansion round
  always @(posedge clk)
    if (kg_en) begin
      s1    <= kg_next_rnd ? key_o : FIPS_KEY;
      key_o <= expand(s1, kg_rcon);
    end
  function automatic logic [7:0] rc(input int r);
    return (r >= 1 && r <= NR) ? rcon_tab[r] : 8'h01;
  endfunction
  function automatic logic [18:0] pack(input logic b, input logic d, input logic v, input logic [3:0] r,
                                       input logic s, input logic e, input logic n, input logic [7:0] c);
    return {b, d, v, r, s, e, n, 1'b1, c};
  endfunction
  function automatic logic [18:0] obs();
    return {busy, done, rk_valid, rk_round, rk_src, kg_en, kg_next_rnd, kg_gen_key, kg_rcon};
  endfunction
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // mode 0: ready always; 1: random ready plus stray starts; 2: 5-cycle stall at round 3
  task automatic run(input int mode, input int abort_at, output int d_at);
    int r, pres, dcyc;
    logic rdy, ev, eb, ee, ab;
    r = 0;
    pres = 1;
    dcyc = 100000;
    d_at = -1;
    start = 1'b1;
    rk_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= ((abort_at > 0) ? abort_at + 3 : dcyc + 1) && c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      ab = (abort_at > 0) && (c > abort_at);
      ev = !ab && r <= NR && c >= pres;
      eb = !ab && c < dcyc;
      ee = eb && !ev;
      check($sformatf("m%0d_c%0d", mode, c), obs(),
            pack(eb, c == dcyc, ev, 4'(ev ? r : 0), ev && r > 0, ee, ee && r != 1, eb ? rc(r) : 8'h01));
      if (ev && r == NR) check($sformatf("rk10_m%0d", mode), key_o, FIPS_RK10);
      if (done && d_at < 0) d_at = c;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : !(r == 3 && c >= pres && c < pres + 5);
      rk_ready = rdy;
      if (mode == 1 && c < dcyc) start = 1'($urandom_range(0, 1));
      if (c == abort_at) abort = 1'b1;
      if (ev && rdy && c != abort_at) begin
        if (r == NR) dcyc = c + 1;
        r++;
        pres = c + PL + 1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rk_ready = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset", obs(), pack(0, 0, 0, 0, 0, 0, 0, 8'h01));
    nrst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("start_abort_1", obs(), pack(0, 0, 0, 0, 0, 0, 0, 8'h01));
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_2", obs(), pack(0, 0, 0, 0, 0, 0, 0, 8'h01));
    run(0, 0, done_at);
    check("done_cycle", done_at, 32);
    run(2, 0, done_at);
    check("stall_done_cycle", done_at, 37);
    run(0, 17, done_at);
    check("abort_no_done", done_at, -1);
    run(0, 0, done_at);
    check("restart_done_cycle", done_at, 32);
    for (int i = 0; i < 4; i++) run(1, 0, done_at);
    rk_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_present", obs(), pack(1, 0, 1, 4'd1, 1, 0, 0, 8'h01));
    #2 nrst = 1'b0;
    #1 check("async_reset", obs(), pack(0, 0, 0, 0, 0, 0, 0, 8'h01));
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", obs(), pack(0, 0, 0, 0, 0, 0, 0, 8'h01));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
